// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shares the 8-bit ALU between the core and a shift-add 8x8 multiplier (optional: MUL_SIGNED_EN)
module alu_mul_sequencer #(
    parameter int ITERS = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  mul_a,
    input  logic [7:0]  mul_b,
`ifdef MUL_SIGNED_EN
    input  logic        mul_signed,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    input  logic        core_req,
    input  logic [2:0]  core_func,
    input  logic [7:0]  core_a,
    input  logic [7:0]  core_b,
    output logic        core_stall,
    output logic [2:0]  alu_func,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out
);

    // ALU opcode encoding shared with the decode/execute stage
    localparam logic [2:0] kADD = 3'd0;
    localparam logic [2:0] kLT  = 3'd5;
    localparam logic [2:0] kSRL = 3'd7;

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TEST   = 3'd1,
        ADD    = 3'd2,
        CARRY  = 3'd3,
        SHR_HI = 3'd4,
        SHR_LO = 3'd5,
        FIX    = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [7:0]  m;
    logic [7:0]  ph;
    logic [7:0]  pl;
    logic [2:0]  cnt;
    logic        cy;
    logic        lsb;
    logic [15:0] product_q;
    logic [7:0]  a_load;
    logic [7:0]  b_load;

`ifdef MUL_SIGNED_EN
    logic        fix_en;
    logic        neg;
    logic [15:0] prod_neg;

    // Signed operands enter the shift-add engine as magnitudes; -128 maps to 0x80
    always_comb begin
        a_load   = (mul_signed && mul_a[7]) ? (~mul_a + 8'd1) : mul_a;
        b_load   = (mul_signed && mul_b[7]) ? (~mul_b + 8'd1) : mul_b;
        prod_neg = ~{ph, pl} + 16'd1;
    end
`else
    // Unsigned only: operands load unchanged
    always_comb begin
        a_load = mul_a;
        b_load = mul_b;
    end
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and ALU steering; the core owns the ALU only while idle
    always_comb begin
        state_n  = state;
        busy     = 1'b1;
        done     = 1'b0;
        alu_func = kADD;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                alu_func = core_func;
                alu_a    = core_a;
                alu_b    = core_b;
                if (start) begin
                    state_n = TEST;
                end
            end
            TEST: begin
                state_n = pl[0] ? ADD : SHR_HI;
            end
            ADD: begin
                alu_func = kADD;
                alu_a    = ph;
                alu_b    = m;
                state_n  = CARRY;
            end
            CARRY: begin
                // Wrapped sum below the addend means the add overflowed
                alu_func = kLT;
                alu_a    = ph;
                alu_b    = m;
                state_n  = SHR_HI;
            end
            SHR_HI: begin
                alu_func = kSRL;
                alu_a    = ph;
                alu_b    = 8'd1;
                state_n  = SHR_LO;
            end
            SHR_LO: begin
                alu_func = kSRL;
                alu_a    = pl;
                alu_b    = 8'd1;
                if (cnt == LAST_ITER) begin
`ifdef MUL_SIGNED_EN
                    state_n = fix_en ? FIX : DONE;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = TEST;
                end
            end
            FIX: begin
                state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Multiply datapath: {cy, PH, PL} shifts right once per iteration
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m         <= 8'd0;
            ph        <= 8'd0;
            pl        <= 8'd0;
            cnt       <= 3'd0;
            cy        <= 1'b0;
            lsb       <= 1'b0;
            product_q <= 16'd0;
`ifdef MUL_SIGNED_EN
            fix_en    <= 1'b0;
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a_load;
                        ph  <= 8'd0;
                        pl  <= b_load;
                        cnt <= 3'd0;
`ifdef MUL_SIGNED_EN
                        fix_en <= mul_signed;
                        neg    <= mul_signed & (mul_a[7] ^ mul_b[7]);
`endif
                    end
                end
                TEST: begin
                    if (!pl[0]) begin
                        cy <= 1'b0;
                    end
                end
                ADD: begin
                    ph <= alu_out;
                end
                CARRY: begin
                    cy <= alu_out[0];
                end
                SHR_HI: begin
                    lsb <= ph[0];
                    ph  <= {cy, alu_out[6:0]};
                end
                SHR_LO: begin
                    pl <= {lsb, alu_out[6:0]};
                    if (cnt != LAST_ITER) begin
                        cnt <= cnt + 3'd1;
                    end
                end
`ifdef MUL_SIGNED_EN
                FIX: begin
                    if (neg) begin
                        {ph, pl} <= prod_neg;
                    end
                end
`endif
                DONE: begin
                    product_q <= {ph, pl};
                end
                default: begin
                end
            endcase
        end
    end

    // The product is presented in the DONE cycle so it is valid alongside done
    assign product    = (state == DONE) ? {ph, pl} : product_q;
    assign core_stall = core_req & busy;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed self-checking bench for alu_mul_sequencer
module tb_alu_mul_sequencer;

    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_SUB = 3'd1;
    localparam logic [2:0] K_AND = 3'd2;
    localparam logic [2:0] K_OR  = 3'd3;
    localparam logic [2:0] K_XOR = 3'd4;
    localparam logic [2:0] K_LT  = 3'd5;
    localparam logic [2:0] K_SLL = 3'd6;
    localparam logic [2:0] K_SRL = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
`ifdef MUL_SIGNED_EN
    logic        mul_signed;
`endif
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        core_req;
    logic [2:0]  core_func;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic        core_stall;
    logic [2:0]  alu_func;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;

    int vectors = 0;
    int miscompares = 0;

    alu_mul_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
`ifdef MUL_SIGNED_EN
        .mul_signed (mul_signed),
`endif
        .busy       (busy),
        .done       (done),
        .product    (product),
        .core_req   (core_req),
        .core_func  (core_func),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_stall (core_stall),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    always #5 Clk = ~Clk;

    // Reference 8-bit ALU
    always_comb begin
        case (alu_func)
            K_ADD:   alu_out = alu_a + alu_b;
            K_SUB:   alu_out = alu_a - alu_b;
            K_AND:   alu_out = alu_a & alu_b;
            K_OR:    alu_out = alu_a | alu_b;
            K_XOR:   alu_out = alu_a ^ alu_b;
            K_LT:    alu_out = {7'd0, alu_a < alu_b};
            K_SLL:   alu_out = alu_a << alu_b[2:0];
            default: alu_out = alu_a >> alu_b[2:0];
        endcase
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic mul_run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input logic [15:0] exp_p, input int exp_lat, input bit disturb,
                           output bit saw_add);
        int  n;
        bit  busy_ok;
        saw_add = 1'b0;
        busy_ok = 1'b1;
        mul_a   = a;
        mul_b   = b;
`ifdef MUL_SIGNED_EN
        mul_signed = sgn;
`else
        if (sgn) $display("note: %s signed request ignored in unsigned build", tag);
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        mul_a = ~a;
        mul_b = ~b;
        if (disturb) begin
            core_req  = 1'b1;
            core_func = K_OR;
            core_a    = 8'h0F;
            core_b    = 8'hF0;
            start     = 1'b1;
            #1;
            check({tag, " stall"}, {15'd0, core_stall}, 16'd1);
            check({tag, " engine_func"}, {13'd0, alu_func}, {13'd0, K_ADD});
            check({tag, " engine_ops"}, {alu_a, alu_b}, 16'h0000);
        end
        n = 1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (busy && alu_func == K_ADD && alu_b != 8'd0) saw_add = 1'b1;
            step();
            start    = 1'b0;
            core_req = 1'b0;
            n++;
        end
        check({tag, " latency"}, 16'(n), 16'(exp_lat));
        check({tag, " product"}, product, exp_p);
        check({tag, " busy_during"}, {15'd0, busy_ok & busy}, 16'd1);
        step();
        check({tag, " busy_after"}, {15'd0, busy}, 16'd0);
        check({tag, " done_after"}, {15'd0, done}, 16'd0);
        check({tag, " product_held"}, product, exp_p);
    endtask

    initial begin
        bit saw_add;
        bit done_seen;
        Reset     = 1'b1;
        start     = 1'b0;
        mul_a     = 8'd0;
        mul_b     = 8'd0;
`ifdef MUL_SIGNED_EN
        mul_signed = 1'b0;
`endif
        core_req  = 1'b0;
        core_func = K_ADD;
        core_a    = 8'd0;
        core_b    = 8'd0;
        step();
        step();
        Reset = 1'b0;
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset done", {15'd0, done}, 16'd0);
        check("reset product", product, 16'h0000);

        // Core owns the ALU while idle
        core_req  = 1'b1;
        core_func = K_OR;
        core_a    = 8'h0F;
        core_b    = 8'hF0;
        #1;
        check("idle alu_out", {8'd0, alu_out}, 16'h00FF);
        check("idle stall", {15'd0, core_stall}, 16'd0);
        step();
        core_req = 1'b0;

        mul_run("13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 31, 1'b1, saw_add);
        mul_run("FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 41, 1'b0, saw_add);
        mul_run("A5x00", 8'hA5, 8'h00, 1'b0, 16'h0000, 25, 1'b0, saw_add);
        check("A5x00 no_add", {15'd0, saw_add}, 16'd0);
        mul_run("80x02", 8'h80, 8'h02, 1'b0, 16'h0100, 27, 1'b0, saw_add);
        check("80x02 add_seen", {15'd0, saw_add}, 16'd1);

        // Reset at T+10 aborts the multiply
        mul_a = 8'd13;
        mul_b = 8'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort busy", {15'd0, busy}, 16'd0);
        check("abort product", product, 16'h0000);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen = 1'b1;
            step();
        end
        check("abort no_done", {15'd0, done_seen}, 16'd0);
        mul_run("07x06", 8'h07, 8'h06, 1'b0, 16'h002A, 29, 1'b0, saw_add);

        // Reset wins over a simultaneous start
        Reset = 1'b1;
        start = 1'b1;
        step();
        Reset = 1'b0;
        start = 1'b0;
        check("reset_vs_start busy", {15'd0, busy}, 16'd0);

`ifdef MUL_SIGNED_EN
        mul_run("sFDx05", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 30, 1'b0, saw_add);
        mul_run("uFDx05", 8'hFD, 8'h05, 1'b0, 16'h04F1, 29, 1'b0, saw_add);
        mul_run("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 28, 1'b0, saw_add);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
